// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard unit: forwarding encodings,
// operand timing (tuse/tnew) classes, default mul/div latencies and slot layout.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_E    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_W    = 2'b11;

  localparam logic [1:0] TUSE_D = 2'd0;
  localparam logic [1:0] TUSE_E = 2'd1;
  localparam logic [1:0] TUSE_M = 2'd2;

  localparam logic [1:0] TNEW_LINK = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  localparam int AW_DEF = 5;
  localparam int TW_DEF = 2;

  // In-flight register write at the default address/tnew widths
  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] addr;
    logic [TW_DEF-1:0] tnew;
  } slot_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Connection bundle between the datapath controller (master) and the hazard
// scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int NSRC = 2,
  parameter int AW   = 5,
  parameter int TW   = 2
);

  logic                 d_valid_i;
  logic [NSRC*AW-1:0]   d_src_addr_i;
  logic [NSRC-1:0]      d_src_use_i;
  logic [NSRC*TW-1:0]   d_src_tuse_i;
  logic                 d_wr_i;
  logic [AW-1:0]        d_wr_addr_i;
  logic [TW-1:0]        d_tnew_i;
  logic                 md_use_d_i;
  logic                 md_start_e_i;
  logic                 md_div_e_i;
  logic                 int_req_i;
  logic                 stall_o;
  logic [2*NSRC-1:0]    fwd_d_o;
  logic [2*NSRC-1:0]    fwd_e_o;
  logic [2*NSRC-1:0]    fwd_m_o;
  logic                 md_busy_o;

  modport master (
    output d_valid_i, d_src_addr_i, d_src_use_i, d_src_tuse_i,
           d_wr_i, d_wr_addr_i, d_tnew_i,
           md_use_d_i, md_start_e_i, md_div_e_i, int_req_i,
    input  stall_o, fwd_d_o, fwd_e_o, fwd_m_o, md_busy_o
  );

  modport slave (
    input  d_valid_i, d_src_addr_i, d_src_use_i, d_src_tuse_i,
           d_wr_i, d_wr_addr_i, d_tnew_i,
           md_use_d_i, md_start_e_i, md_div_e_i, int_req_i,
    output stall_o, fwd_d_o, fwd_e_o, fwd_m_o, md_busy_o
  );

endinterface

// File: rtl/hazard_match.sv
// Compares one source operand against the E/M/W write slots and reports the
// youngest matching stage together with that producer's remaining tnew.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int AW = 5,
  parameter int TW = 2
) (
  input  logic [AW-1:0] src_addr,
  input  logic          e_valid,
  input  logic [AW-1:0] e_addr,
  input  logic [TW-1:0] e_tnew,
  input  logic          m_valid,
  input  logic [AW-1:0] m_addr,
  input  logic [TW-1:0] m_tnew,
  input  logic          w_valid,
  input  logic [AW-1:0] w_addr,
  input  logic [TW-1:0] w_tnew,
  output logic          hit,
  output logic [1:0]    stage,
  output logic [TW-1:0] tnew
);

  // Priority search, youngest producer first; $0 is hard-wired and never matches
  always_comb begin
    hit   = 1'b0;
    stage = FWD_NONE;
    tnew  = '0;
    if (src_addr == '0) begin
      hit = 1'b0;
    end else if (e_valid && (e_addr == src_addr)) begin
      hit   = 1'b1;
      stage = FWD_E;
      tnew  = e_tnew;
    end else if (m_valid && (m_addr == src_addr)) begin
      hit   = 1'b1;
      stage = FWD_M;
      tnew  = m_tnew;
    end else if (w_valid && (w_addr == src_addr)) begin
      hit   = 1'b1;
      stage = FWD_W;
      tnew  = w_tnew;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: stall, operand forwarding and mul/div busy.
// Optional HAZARD_STATS_EN adds stall_cnt_o, a wrapping count of stalled cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSRC    = 2,
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]         stall_cnt_o
`endif
);

  localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MDW    = $clog2(MD_MAX + 1);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [TW-1:0] tnew;
  } wslot_t;

  wslot_t slot_e_r, slot_m_r, slot_w_r;
  wslot_t slot_e_nxt_s, slot_m_nxt_s, slot_w_nxt_s;

  logic [NSRC*AW-1:0] e_src_addr_r, m_src_addr_r;
  logic [NSRC-1:0]    e_src_use_r, m_src_use_r;

  logic [MDW-1:0] md_cnt_r, md_cnt_nxt_s;
  logic           md_busy_s;
  logic           raw_hz_s;
  logic           md_hz_s;
  logic           stall_s;

  logic [NSRC-1:0] d_hit_s, e_hit_s, m_hit_s;
  logic [1:0]      d_stage_s [NSRC];
  logic [1:0]      e_stage_s [NSRC];
  logic [1:0]      m_stage_s [NSRC];
  logic [TW-1:0]   d_tnew_s  [NSRC];
  logic [TW-1:0]   e_tnew_s  [NSRC];
  logic [TW-1:0]   m_tnew_s  [NSRC];

  // A consumer only looks at producers older than itself, so E sees M/W and M sees W
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    hazard_match #(.AW(AW), .TW(TW)) u_match_d (
      .src_addr (bus.d_src_addr_i[i*AW +: AW]),
      .e_valid  (slot_e_r.valid), .e_addr (slot_e_r.addr), .e_tnew (slot_e_r.tnew),
      .m_valid  (slot_m_r.valid), .m_addr (slot_m_r.addr), .m_tnew (slot_m_r.tnew),
      .w_valid  (slot_w_r.valid), .w_addr (slot_w_r.addr), .w_tnew (slot_w_r.tnew),
      .hit      (d_hit_s[i]), .stage (d_stage_s[i]), .tnew (d_tnew_s[i])
    );
    hazard_match #(.AW(AW), .TW(TW)) u_match_e (
      .src_addr (e_src_addr_r[i*AW +: AW]),
      .e_valid  (1'b0), .e_addr ('0), .e_tnew ('0),
      .m_valid  (slot_m_r.valid), .m_addr (slot_m_r.addr), .m_tnew (slot_m_r.tnew),
      .w_valid  (slot_w_r.valid), .w_addr (slot_w_r.addr), .w_tnew (slot_w_r.tnew),
      .hit      (e_hit_s[i]), .stage (e_stage_s[i]), .tnew (e_tnew_s[i])
    );
    hazard_match #(.AW(AW), .TW(TW)) u_match_m (
      .src_addr (m_src_addr_r[i*AW +: AW]),
      .e_valid  (1'b0), .e_addr ('0), .e_tnew ('0),
      .m_valid  (1'b0), .m_addr ('0), .m_tnew ('0),
      .w_valid  (slot_w_r.valid), .w_addr (slot_w_r.addr), .w_tnew (slot_w_r.tnew),
      .hit      (m_hit_s[i]), .stage (m_stage_s[i]), .tnew (m_tnew_s[i])
    );
  end

  // Stall decision: late producer for any read operand, or mul/div unit occupied
  always_comb begin
    raw_hz_s = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      raw_hz_s = raw_hz_s | (bus.d_src_use_i[i] & d_hit_s[i] &
                             (d_tnew_s[i] > bus.d_src_tuse_i[i*TW +: TW]));
    end
    md_hz_s = bus.md_use_d_i & (md_busy_s | bus.md_start_e_i);
    stall_s = ~bus.int_req_i & (raw_hz_s | md_hz_s);
  end

  // Forward selects are only meaningful once the producer's result exists (tnew 0)
  always_comb begin
    bus.fwd_d_o = '0;
    bus.fwd_e_o = '0;
    bus.fwd_m_o = '0;
    for (int i = 0; i < NSRC; i++) begin
      bus.fwd_d_o[2*i +: 2] = (d_hit_s[i] && (d_tnew_s[i] == '0)) ? d_stage_s[i] : FWD_NONE;
      bus.fwd_e_o[2*i +: 2] = (e_src_use_r[i] && e_hit_s[i] && (e_tnew_s[i] == '0)) ?
                              e_stage_s[i] : FWD_NONE;
      bus.fwd_m_o[2*i +: 2] = (m_src_use_r[i] && m_hit_s[i] && (m_tnew_s[i] == '0)) ?
                              m_stage_s[i] : FWD_NONE;
    end
  end

  // Next shadow-pipeline contents; an interrupt kills D and E but lets M retire
  always_comb begin
    slot_e_nxt_s      = '0;
    slot_m_nxt_s      = '0;
    slot_w_nxt_s      = slot_m_r;
    slot_w_nxt_s.tnew = '0;
    if (bus.int_req_i) begin
      slot_e_nxt_s = '0;
      slot_m_nxt_s = '0;
    end else begin
      slot_m_nxt_s      = slot_e_r;
      slot_m_nxt_s.tnew = (slot_e_r.tnew == '0) ? '0 : (slot_e_r.tnew - TW'(1));
      if (stall_s) begin
        slot_e_nxt_s = '0;
      end else begin
        slot_e_nxt_s.valid = bus.d_valid_i & bus.d_wr_i & (bus.d_wr_addr_i != '0);
        slot_e_nxt_s.addr  = bus.d_wr_addr_i;
        slot_e_nxt_s.tnew  = bus.d_tnew_i;
      end
    end
  end

  // Mul/div countdown; a new start (even while busy) reloads, an interrupt drops the start
  always_comb begin
    md_cnt_nxt_s = md_cnt_r;
    if (bus.md_start_e_i && !bus.int_req_i) begin
      md_cnt_nxt_s = bus.md_div_e_i ? MDW'(DIV_LAT) : MDW'(MUL_LAT);
    end else if (md_cnt_r != '0) begin
      md_cnt_nxt_s = md_cnt_r - MDW'(1);
    end else begin
      md_cnt_nxt_s = md_cnt_r;
    end
  end

  // Shadow slots, operand pipeline and mul/div counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_e_r     <= '0;
      slot_m_r     <= '0;
      slot_w_r     <= '0;
      e_src_addr_r <= '0;
      e_src_use_r  <= '0;
      m_src_addr_r <= '0;
      m_src_use_r  <= '0;
      md_cnt_r     <= '0;
    end else begin
      slot_e_r <= slot_e_nxt_s;
      slot_m_r <= slot_m_nxt_s;
      slot_w_r <= slot_w_nxt_s;
      md_cnt_r <= md_cnt_nxt_s;
      if (bus.int_req_i) begin
        e_src_addr_r <= '0;
        e_src_use_r  <= '0;
        m_src_addr_r <= '0;
        m_src_use_r  <= '0;
      end else begin
        m_src_addr_r <= e_src_addr_r;
        m_src_use_r  <= e_src_use_r;
        if (stall_s) begin
          e_src_addr_r <= '0;
          e_src_use_r  <= '0;
        end else begin
          e_src_addr_r <= bus.d_src_addr_i;
          e_src_use_r  <= bus.d_src_use_i & {NSRC{bus.d_valid_i}};
        end
      end
    end
  end

  assign md_busy_s     = (md_cnt_r != '0);
  assign bus.md_busy_o = md_busy_s;
  assign bus.stall_o   = stall_s;

`ifdef HAZARD_STATS_EN
  // Stalled-cycle counter; stall_s is already low whenever an interrupt is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= 32'd0;
    end else if (stall_s) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end else begin
      stall_cnt_o <= stall_cnt_o;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, stall/forward scenarios, mul/div
// countdown, interrupts and asynchronous reset.
module tb_hazard_scoreboard;

  localparam int NSRC = 2;
  localparam int AW = 5;
  localparam int TW = 2;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   n;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
`endif

  hazard_scoreboard_if #(.NSRC(NSRC), .AW(AW), .TW(TW)) bus ();

  hazard_scoreboard #(
    .NSRC(NSRC), .AW(AW), .TW(TW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [4:0] a0, input logic u0, input logic [1:0] t0,
                       input logic [4:0] a1, input logic u1, input logic [1:0] t1,
                       input logic wr, input logic [4:0] wa, input logic [1:0] tn);
    bus.d_valid_i    = v;
    bus.d_src_addr_i = {a1, a0};
    bus.d_src_use_i  = {u1, u0};
    bus.d_src_tuse_i = {t1, t0};
    bus.d_wr_i       = wr;
    bus.d_wr_addr_i  = wa;
    bus.d_tnew_i     = tn;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0);
    bus.md_use_d_i   = 1'b0;
    bus.md_start_e_i = 1'b0;
    bus.md_div_e_i   = 1'b0;
    bus.int_req_i    = 1'b0;
  endtask

  task automatic flush();
    idle();
    repeat (4) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", bus.stall_o); end
    checks++; if (bus.fwd_d_o !== 4'b0000) begin errors++; $display("FAIL rst_fwd_d: got %b want 0000", bus.fwd_d_o); end
    checks++; if (bus.fwd_e_o !== 4'b0000) begin errors++; $display("FAIL rst_fwd_e: got %b want 0000", bus.fwd_e_o); end
    checks++; if (bus.fwd_m_o !== 4'b0000) begin errors++; $display("FAIL rst_fwd_m: got %b want 0000", bus.fwd_m_o); end
    checks++; if (bus.md_busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.md_busy_o); end
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL post_rst_stall: got %b want 0", bus.stall_o); end
  endtask

  task automatic test_alu_branch();
    cyc(); drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd3, 2'd1);
    cyc(); drive(1'b1, 5'd3, 1'b1, 2'd0, 5'd3, 1'b1, 2'd0, 1'b0, 5'd0, 2'd0);
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL alu_beq_stall: got %b want 1", bus.stall_o); end
    checks++; if (bus.fwd_d_o !== 4'b0000) begin errors++; $display("FAIL alu_beq_fwd0: got %b want 0000", bus.fwd_d_o); end
    cyc();
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL alu_beq_release: got %b want 0", bus.stall_o); end
    checks++; if (bus.fwd_d_o !== 4'b1010) begin errors++; $display("FAIL alu_beq_fwd_m: got %b want 1010", bus.fwd_d_o); end
    cyc(); idle();
    @(negedge clk);
    checks++; if (bus.fwd_e_o !== 4'b1111) begin errors++; $display("FAIL alu_beq_fwd_e_w: got %b want 1111", bus.fwd_e_o); end
    flush();
  endtask

  task automatic test_load_use();
    cyc(); drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd5, 2'd2);
    cyc(); drive(1'b1, 5'd0, 1'b1, 2'd1, 5'd5, 1'b1, 2'd1, 1'b1, 5'd6, 2'd1);
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b want 1", bus.stall_o); end
    cyc();
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b want 0", bus.stall_o); end
    checks++; if (bus.fwd_d_o !== 4'b0000) begin errors++; $display("FAIL load_use_fwd_d: got %b want 0000", bus.fwd_d_o); end
    cyc(); idle();
    @(negedge clk);
    checks++; if (bus.fwd_e_o !== 4'b1100) begin errors++; $display("FAIL load_use_fwd_e: got %b want 1100", bus.fwd_e_o); end
    flush();
  endtask

  task automatic test_store_fwd();
    cyc(); drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd8, 2'd1);
    cyc(); drive(1'b1, 5'd8, 1'b1, 2'd2, 5'd9, 1'b1, 2'd1, 1'b0, 5'd0, 2'd0);
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL store_stall: got %b want 0", bus.stall_o); end
    cyc(); idle();
    @(negedge clk);
    checks++; if (bus.fwd_e_o !== 4'b0010) begin errors++; $display("FAIL store_fwd_e: got %b want 0010", bus.fwd_e_o); end
    cyc();
    @(negedge clk);
    checks++; if (bus.fwd_m_o !== 4'b0011) begin errors++; $display("FAIL store_fwd_m: got %b want 0011", bus.fwd_m_o); end
    flush();
  endtask

  task automatic test_youngest();
    cyc(); drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd4, 2'd1);
    cyc(); drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd4, 2'd2);
    cyc(); drive(1'b1, 5'd4, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0);
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL young_stall: got %b want 1", bus.stall_o); end
    checks++; if (bus.fwd_d_o !== 4'b0000) begin errors++; $display("FAIL young_no_fwd_m: got %b want 0000", bus.fwd_d_o); end
    cyc();
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL young_release: got %b want 0", bus.stall_o); end
    checks++; if (bus.fwd_d_o !== 4'b0000) begin errors++; $display("FAIL young_no_fwd_w: got %b want 0000", bus.fwd_d_o); end
    flush();
  endtask

  task automatic test_jal();
    cyc(); drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd31, 2'd0);
    cyc(); drive(1'b1, 5'd31, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 2'd0);
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL jal_stall: got %b want 0", bus.stall_o); end
    checks++; if (bus.fwd_d_o !== 4'b0001) begin errors++; $display("FAIL jal_fwd_e: got %b want 0001", bus.fwd_d_o); end
    flush();
  endtask

  task automatic test_muldiv();
    cyc();
    bus.md_start_e_i = 1'b1; bus.md_div_e_i = 1'b0; bus.md_use_d_i = 1'b1; bus.d_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.stall_o === 1'b1 && n < 40) begin
      n++; cyc(); bus.md_start_e_i = 1'b0; @(negedge clk);
    end
    checks++; if (n !== MUL_LAT + 1) begin errors++; $display("FAIL mult_stall_cycles: got %0d want %0d", n, MUL_LAT + 1); end
    checks++; if (bus.md_busy_o !== 1'b0) begin errors++; $display("FAIL mult_busy_end: got %b want 0", bus.md_busy_o); end
    cyc(); idle();
    bus.md_start_e_i = 1'b1; bus.md_div_e_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL div_no_user_stall: got %b want 0", bus.stall_o); end
    cyc(); bus.md_start_e_i = 1'b0; bus.md_use_d_i = 1'b1; bus.d_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.stall_o === 1'b1 && n < 40) begin
      n++; cyc(); @(negedge clk);
    end
    checks++; if (n !== DIV_LAT) begin errors++; $display("FAIL div_stall_cycles: got %0d want %0d", n, DIV_LAT); end
    cyc(); idle();
    bus.md_start_e_i = 1'b1;
    cyc(); bus.md_start_e_i = 1'b0;
    cyc(); bus.md_start_e_i = 1'b1; bus.md_div_e_i = 1'b1;
    cyc(); bus.md_start_e_i = 1'b0; bus.md_div_e_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.md_busy_o === 1'b1 && n < 40) begin
      n++; cyc(); @(negedge clk);
    end
    checks++; if (n !== DIV_LAT) begin errors++; $display("FAIL reload_busy_cycles: got %0d want %0d", n, DIV_LAT); end
    flush();
  endtask

  task automatic test_interrupt();
    cyc(); drive(1'b1, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 5'd2, 2'd2);
    cyc(); drive(1'b1, 5'd2, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b1, 5'd7, 2'd1);
    bus.int_req_i = 1'b1; bus.md_start_e_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL int_stall_forced: got %b want 0", bus.stall_o); end
    cyc(); bus.int_req_i = 1'b0; bus.md_start_e_i = 1'b0;
    drive(1'b1, 5'd2, 1'b1, 2'd0, 5'd7, 1'b1, 2'd0, 1'b0, 5'd0, 2'd0);
    @(negedge clk);
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL int_slots_killed: got %b want 0", bus.stall_o); end
    checks++; if (bus.fwd_d_o !== 4'b0000) begin errors++; $display("FAIL int_fwd_d: got %b want 0000", bus.fwd_d_o); end
    checks++; if (bus.md_busy_o !== 1'b0) begin errors++; $display("FAIL int_md_start_ignored: got %b want 0", bus.md_busy_o); end
    flush();
  endtask

  task automatic test_async_reset();
    cyc(); bus.md_start_e_i = 1'b1;
    cyc(); bus.md_start_e_i = 1'b0; bus.md_use_d_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.md_busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", bus.md_busy_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.md_busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", bus.md_busy_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL arst_stall: got %b want 0", bus.stall_o); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    cyc();
    @(negedge clk);
    checks++; if (bus.md_busy_o !== 1'b0) begin errors++; $display("FAIL arst_release_busy: got %b want 0", bus.md_busy_o); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_alu_branch();
    test_load_use();
    test_store_fwd();
    test_youngest();
    test_jal();
    test_muldiv();
    test_interrupt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
